regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
- Parametrised multi-port successor to the processor's 32x32 register file.
- Configurable data width, depth, and read/write port counts.
- Optional same-cycle write-to-read bypass and optional hardwired-zero register 0.
- Sequenced clear engine zeroes the array one entry per cycle on request, without a full reset; used by the microcode sequencer for context flush.

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of entries; power of two, ≥2. Localparam AW = $clog2(NUM_REGS).
- NUM_RD, 2, number of asynchronous read ports, 1..4.
- NUM_WR, 1, number of synchronous write ports, 1..2.
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes.
- BYPASS, 0, 1 = read returns the same-cycle write data on an address match.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, synchronous active-low reset.
- rd_addr, in, NUM_RD*AW, read addresses; port k at [k*AW +: AW].
- rd_data, out, NUM_RD*DATA_W, read data; port k at [k*DATA_W +: DATA_W].
- wr_en, in, NUM_WR, per-port write enable.
- wr_addr, in, NUM_WR*AW, write addresses.
- wr_data, in, NUM_WR*DATA_W, write data.
- wr_rdy, out, 1, writes accepted this cycle.
- clr_req, in, 1, start sequenced clear (level sampled in IDLE).
- clr_busy, out, 1, clear in progress.
- clr_done, out, 1, one-cycle pulse when the clear completes.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-low: rst_n is sampled at the clk rising edge; rst_n=0 means reset.
- Reset (rst_n=0 at edge):
  - All entries ← 0.
  - FSM ← IDLE, clear index ← 0.
  - clr_busy=0, clr_done=0, wr_rdy=1.
  - Reset overrides writes and an in-progress clear.
- FSM states:
  - IDLE:
    - wr_rdy=1.
    - clr_req=1 at edge → CLEAR, index ← 0 (or ← 1 when ZERO_REG=1).
    - Writes presented in that same cycle still commit.
  - CLEAR:
    - clr_busy=1, wr_rdy=0. Writes are dropped, not queued; the upstream holds them until wr_rdy=1.
    - Each cycle: entry[index] ← 0, index ← index+1.
    - When the entry NUM_REGS-1 write occurs → IDLE, with clr_done=1 for the following cycle only.
    - clr_req is ignored while in CLEAR.
  - Total clear time: NUM_REGS cycles (NUM_REGS-1 when ZERO_REG=1). clr_busy drops in the same cycle clr_done rises.
- Writes (IDLE only):
  - entry[wr_addr[j]] ← wr_data[j] at the edge when wr_en[j]=1.
  - When ZERO_REG=1, writes to address 0 are discarded.
  - Two ports to the same address in one cycle: the higher port index wins.
- Reads:
  - Combinational, zero latency: rd_data[k] = entry[rd_addr[k]].
  - ZERO_REG=1 and rd_addr[k]=0 → 0, regardless of bypass.
  - BYPASS=1, wr_rdy=1, and an enabled write port matches rd_addr[k] → that port's wr_data; the highest matching port index wins.
  - BYPASS=0 → pre-edge array value (read-old).
  - During CLEAR, reads return current array contents: entries below index are already 0, the rest hold old values. No bypass, because writes are blocked.
- Width: no arithmetic on data. Index counter is AW+1 bits so NUM_REGS-1 terminates cleanly without wrap.
- Outputs are never X after the first reset edge. An initial block also zeroes the array for simulation.

Test Plan:
- Reset then readback: rst_n=0 for 2 cycles, then read all 32 addresses on both ports → all 0x00000000, wr_rdy=1, clr_busy=0.
- Basic write/read, plus zero register: write 0xDEADBEEF to r5, then 0x12345678 to r0; read r5/r0 → 0xDEADBEEF/0x00000000. With ZERO_REG=0, r0 → 0x12345678.
- Dual-write collision (NUM_WR=2): both ports write r7 with 0xAAAA0000 (port 0) and 0x5555FFFF (port 1) → r7=0x5555FFFF. With BYPASS=1, a same-cycle read of r7 returns 0x5555FFFF. With BYPASS=0 it returns the old value and 0x5555FFFF next cycle.
- Sequenced clear, no pending writes:
  - Fill r1..r31 with value=index, then pulse clr_req.
  - clr_busy=1 for exactly 31 cycles, then clr_done high for one cycle.
  - Mid-clear (cycle 10) read of r20 → 20 and of r3 → 0. After completion, all entries read 0.
- Write attempted during clear:
  - During CLEAR, assert wr_en to r31 with 0xCAFEF00D → wr_rdy=0 and the write is dropped; r31 reads 0 after clr_done.
  - Re-issue the write after clr_done → 0xCAFEF00D.
- Reset mid-clear: pull rst_n=0 at CLEAR cycle 5 → next cycle clr_busy=0, clr_done never pulses, all entries 0, FSM IDLE. A new clr_req restarts from index 1.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a sequenced clear engine.
//   clk, rst_n         : clock, synchronous active-low reset
//   rd_addr / rd_data  : NUM_RD asynchronous read ports (port k at [k*AW +: AW] / [k*DATA_W +: DATA_W])
//   wr_en / wr_addr /
//   wr_data            : NUM_WR synchronous write ports, committed only while wr_rdy=1
//   wr_rdy             : writes are accepted this cycle (low while clearing)
//   clr_req            : start a sequenced clear (level, sampled in IDLE)
//   clr_busy           : clear in progress
//   clr_done           : one-cycle pulse after the last entry is cleared
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 0,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*AW-1:0]       rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*AW-1:0]       wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  output logic                       wr_rdy,
  input  logic                       clr_req,
  output logic                       clr_busy,
  output logic                       clr_done
);

  // Index is one bit wider than the address so the last entry never wraps.
  localparam int unsigned IW = AW + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rdy_q, rdy_d;

  assign wr_rdy   = rdy_q;
  assign clr_busy = busy_q;
  assign clr_done = done_q;

  // Next-state, array update and registered status flags.
  always_comb begin : fsm_next
    logic [AW-1:0] wa;
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = (state_q == ST_CLEAR);
    done_d  = 1'b0;
    rdy_d   = (state_q == ST_IDLE);
    mem_d   = mem_q;
    wa      = '0;

    case (state_q)
      ST_IDLE: begin
        // Ascending port order: the highest-indexed port wins a collision.
        for (int j = 0; j < int'(NUM_WR); j++) begin
          wa = wr_addr[j*AW +: AW];
          if (wr_en[j] && !((ZERO_REG != 0) && (wa == '0))) begin
            mem_d[wa] = wr_data[j*DATA_W +: DATA_W];
          end
        end
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = (ZERO_REG != 0) ? IW'(1) : IW'(0);
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
        end
      end

      ST_CLEAR: begin
        // Writes are dropped here; one entry is zeroed per cycle.
        mem_d[idx_q[AW-1:0]] = '0;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(NUM_REGS - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rdy_d   = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and array registers; reset overrides writes and any clear in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b1;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdy_q   <= rdy_d;
      mem_q   <= mem_d;
    end
  end

  // Read ports: array value, optional same-cycle bypass, zero register has final say.
  always_comb begin : rd_mux
    logic [AW-1:0]     ra;
    logic [DATA_W-1:0] rv;
    rd_data = '0;
    ra      = '0;
    rv      = '0;
    for (int k = 0; k < int'(NUM_RD); k++) begin
      ra = rd_addr[k*AW +: AW];
      rv = mem_q[ra];
      if ((BYPASS != 0) && rdy_q) begin
        for (int j = 0; j < int'(NUM_WR); j++) begin
          if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) begin
            rv = wr_data[j*DATA_W +: DATA_W];
          end
        end
      end
      if ((ZERO_REG != 0) && (ra == '0)) begin
        rv = '0;
      end
      rd_data[k*DATA_W +: DATA_W] = rv;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: instance a (2 write ports, zero register, bypass) carries the
// main sequence; instance b (2 write ports, no zero register, read-old) shares the
// write/read stimulus to cover the other parameter choices.
module tb_regfile_mp;

  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic [NRD*AW-1:0]  rd_addr;
  logic [NRD*DW-1:0]  rd_data_a, rd_data_b;
  logic [NWR-1:0]     wr_en;
  logic [NWR*AW-1:0]  wr_addr;
  logic [NWR*DW-1:0]  wr_data;
  logic               wr_rdy_a, clr_req_a, clr_busy_a, clr_done_a;
  logic               wr_rdy_b, clr_req_b, clr_busy_b, clr_done_b;

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR),
               .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy_a),
    .clr_req(clr_req_a), .clr_busy(clr_busy_a), .clr_done(clr_done_a));

  regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR),
               .ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_rdy(wr_rdy_b),
    .clr_req(clr_req_b), .clr_busy(clr_busy_b), .clr_done(clr_done_b));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] model_a [NR];
  logic [31:0] model_b [NR];

  function automatic logic [31:0] rda(input int k);
    return rd_data_a[k*DW +: DW];
  endfunction

  function automatic logic [31:0] rdb(input int k);
    return rd_data_b[k*DW +: DW];
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    n_checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {5'(a1), 5'(a0)};
  endtask

  task automatic commit(input logic [1:0] en, input int a0, input logic [31:0] d0,
                        input int a1, input logic [31:0] d1, input bit a_on);
    if (en[0]) begin
      model_b[a0] = d0;
      if (a_on && a0 != 0) model_a[a0] = d0;
    end
    if (en[1]) begin
      model_b[a1] = d1;
      if (a_on && a1 != 0) model_a[a1] = d1;
    end
  endtask

  // One write cycle: drive after a falling edge, commit at the next rising edge.
  task automatic wr_cycle(input logic [1:0] en, input int a0, input logic [31:0] d0,
                          input int a1, input logic [31:0] d1);
    @(negedge clk);
    wr_en   = en;
    wr_addr = {5'(a1), 5'(a0)};
    wr_data = {d1, d0};
    @(negedge clk);
    wr_en = '0;
    commit(en, a0, d0, a1, d1, 1'b1);
  endtask

  task automatic readback_zero(input string tag);
    for (int i = 0; i < int'(NR); i++) begin
      @(negedge clk);
      set_rd(i, int'(NR) - 1 - i);
      #1;
      push({tag, "_p0"}, 32'h0); pop_check(rda(0));
      push({tag, "_p1"}, 32'h0); pop_check(rda(1));
    end
  endtask

  task automatic chk_status(input string tag, input bit busy, input bit done, input bit rdy);
    push({tag, "_busy"}, 32'(busy)); pop_check(32'(clr_busy_a));
    push({tag, "_done"}, 32'(done)); pop_check(32'(clr_done_a));
    push({tag, "_rdy"},  32'(rdy));  pop_check(32'(wr_rdy_a));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "simulation did not complete");
  end

  initial begin
    int unsigned busy_cnt;
    bit          done_seen;

    rst_n     = 1'b0;
    rd_addr   = '0;
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    clr_req_a = 1'b0;
    clr_req_b = 1'b0;
    for (int i = 0; i < int'(NR); i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end

    // Reset for two edges, then every entry reads zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_status("reset", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < int'(NR); i++) begin
      @(negedge clk);
      set_rd(i, int'(NR) - 1 - i);
      #1;
      push("rst_rd_a0", 32'h0); pop_check(rda(0));
      push("rst_rd_a1", 32'h0); pop_check(rda(1));
      push("rst_rd_b0", 32'h0); pop_check(rdb(0));
    end

    // Basic write/read and the zero register.
    wr_cycle(2'b01, 5, 32'hDEADBEEF, 0, 32'h0);
    wr_cycle(2'b01, 0, 32'h12345678, 0, 32'h0);
    set_rd(5, 0);
    #1;
    push("wr_r5_a", 32'hDEADBEEF);      pop_check(rda(0));
    push("zero_r0_a", 32'h0);           pop_check(rda(1));
    push("wr_r5_b", 32'hDEADBEEF);      pop_check(rdb(0));
    push("nozero_r0_b", 32'h12345678);  pop_check(rdb(1));

    // Dual-write collision on r7, read in the same cycle.
    @(negedge clk);
    wr_en   = 2'b11;
    wr_addr = {5'd7, 5'd7};
    wr_data = {32'h5555FFFF, 32'hAAAA0000};
    set_rd(7, 5);
    #1;
    push("coll_bypass_a", 32'h5555FFFF);  pop_check(rda(0));
    push("nomatch_a", 32'hDEADBEEF);      pop_check(rda(1));
    push("coll_readold_b", 32'h0);        pop_check(rdb(0));
    @(negedge clk);
    wr_en = '0;
    commit(2'b11, 7, 32'hAAAA0000, 7, 32'h5555FFFF, 1'b1);
    #1;
    push("coll_after_a", 32'h5555FFFF);   pop_check(rda(0));
    push("coll_after_b", 32'h5555FFFF);   pop_check(rdb(0));

    // Bypass on port 1 while port 0 writes r0: zero register beats bypass.
    @(negedge clk);
    wr_en   = 2'b11;
    wr_addr = {5'd9, 5'd0};
    wr_data = {32'h00000099, 32'hFFFFFFFF};
    set_rd(0, 9);
    #1;
    push("zero_vs_bypass_a", 32'h0);      pop_check(rda(0));
    push("bypass_r9_a", 32'h00000099);    pop_check(rda(1));
    push("readold_r0_b", 32'h12345678);   pop_check(rdb(0));
    push("readold_r9_b", 32'h0);          pop_check(rdb(1));
    @(negedge clk);
    wr_en = '0;
    commit(2'b11, 0, 32'hFFFFFFFF, 9, 32'h00000099, 1'b1);
    #1;
    push("r0_after_a", 32'h0);            pop_check(rda(0));
    push("r0_after_b", 32'hFFFFFFFF);     pop_check(rdb(0));
    push("r9_after_b", 32'h00000099);     pop_check(rdb(1));

    // Fill r1..r31 with their own index.
    for (int i = 1; i < int'(NR); i++) begin
      wr_cycle(2'b10, 0, 32'h0, i, 32'(i));
    end
    set_rd(17, 31);
    #1;
    push("fill_r17", model_a[17]); pop_check(rda(0));
    push("fill_r31", 32'd31);      pop_check(rda(1));

    // Sequenced clear with a write attempted mid-way.
    @(negedge clk);
    clr_req_a = 1'b1;
    @(negedge clk);
    clr_req_a = 1'b0;
    for (int n = 1; n <= 33; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 21) begin
        wr_en = '0;
        commit(2'b11, 31, 32'hCAFEF00D, 2, 32'h00000BAD, 1'b0);
      end
      if (n == 20) begin
        wr_en   = 2'b11;
        wr_addr = {5'd2, 5'd31};
        wr_data = {32'h00000BAD, 32'hCAFEF00D};
      end
      #1;
      chk_status("clr", n <= 31, n == 32, n >= 32);
      if (n == 10) begin
        set_rd(20, 3);
        #1;
        push("midclr_r20", 32'd20); pop_check(rda(0));
        push("midclr_r3", 32'd0);   pop_check(rda(1));
      end
      if (n == 20) begin
        set_rd(2, 31);
        #1;
        push("clr_nobypass_r2", 32'd0);  pop_check(rda(0));
        push("clr_old_r31", 32'd31);     pop_check(rda(1));
      end
    end
    for (int i = 0; i < int'(NR); i++) model_a[i] = '0;
    readback_zero("after_clr");

    // The dropped write is re-issued once the clear is done.
    wr_cycle(2'b01, 31, 32'hCAFEF00D, 0, 32'h0);
    set_rd(31, 2);
    #1;
    push("reissue_r31", 32'hCAFEF00D); pop_check(rda(0));
    push("dropped_r2", 32'h0);         pop_check(rda(1));

    // Reset in the middle of a clear.
    wr_cycle(2'b01, 10, 32'h00000010, 0, 32'h0);
    @(negedge clk);
    clr_req_a = 1'b1;
    @(negedge clk);
    clr_req_a = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk_status("clr_c5", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk_status("rst_midclr", 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk_status("post_rst", 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < int'(NR); i++) begin
      model_a[i] = '0;
      model_b[i] = '0;
    end
    readback_zero("after_rst");

    // Restarted clear begins at index 1; clr_req held into CLEAR is ignored.
    wr_cycle(2'b11, 1, 32'h00000011, 2, 32'h00000022);
    @(negedge clk);
    clr_req_a = 1'b1;
    @(negedge clk);
    set_rd(1, 2);
    #1;
    chk_status("restart_c1", 1'b1, 1'b0, 1'b0);
    push("restart_c1_r1", 32'h00000011); pop_check(rda(0));
    push("restart_c1_r2", 32'h00000022); pop_check(rda(1));
    @(negedge clk);
    #1;
    push("restart_c2_r1", 32'h0);        pop_check(rda(0));
    push("restart_c2_r2", 32'h00000022); pop_check(rda(1));
    clr_req_a = 1'b0;
    busy_cnt  = 2;
    done_seen = 1'b0;
    for (int n = 3; n <= 40; n++) begin
      @(negedge clk);
      #1;
      if (clr_done_a) begin
        done_seen = 1'b1;
        break;
      end
      if (clr_busy_a) busy_cnt++;
    end
    push("restart_done_seen", 32'd1);  pop_check(32'(done_seen));
    push("restart_busy_cycles", 32'd31); pop_check(32'(busy_cnt));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
